// File: rtl/rk8e_databreak.sv
// -----------------------------------------------------------------------------
// rk8e_databreak
//
// Single-cycle data-break sequencer between the RK8E disk controller and
// PDP-8/E main memory. Word-transfer requests from the disk side are queued
// in a 2-entry FIFO. For each queued word the block raises a break request
// to the CPU, and once the break is granted it runs one DB0/DB1 memory
// cycle. Completion (plus read data for reads) goes back to the disk side.
//
// Bit 0 is the MSB on every multi-bit PDP-8 bus.
//
// Parameters
//   MEM_LAT       cycles from the memory strobe until mem_rdata is valid (1..7)
//   DEPTH         request FIFO depth, fixed at 2
//
// Ports
//   clk, reset    system clock, synchronous active-high reset
//   clear         IOCLR/CAF: flushes queued requests, suppresses a pending rsp
//   req_*         disk-side request (valid/ready, write, addr[0:14], data[0:11])
//   rsp_valid     one-cycle completion pulse (reads and writes)
//   rsp_data      read data, held until the next read completes
//   brk_req       data-break request to the CPU
//   brk_grant     CPU grants the break (only looked at while requesting)
//   break_in_prog memory cycle owned by this block (DB0/DB1)
//   mem_*         memory address, write data, write/read strobes, read data
//   count         FIFO occupancy, 0..2
// -----------------------------------------------------------------------------
module rk8e_databreak #(
    parameter int MEM_LAT = 1,
    parameter int DEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [0:14] req_addr,
    input  logic [0:11] req_data,
    output logic        rsp_valid,
    output logic [0:11] rsp_data,
    output logic        brk_req,
    input  logic        brk_grant,
    output logic        break_in_prog,
    output logic [0:14] mem_addr,
    output logic [0:11] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [0:11] mem_rdata,
    output logic [1:0]  count
);

    localparam logic [1:0] FULL_COUNT = 2'(DEPTH);
    localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BRK,
        DB0,
        DB1,
        RESP
    } state_t;

    typedef struct packed {
        logic        write;
        logic [0:14] addr;
        logic [0:11] data;
    } entry_t;

    state_t      state;
    state_t      state_next;

    entry_t      fifo_mem [0:1];
    entry_t      head;
    logic        wr_ptr;
    logic        rd_ptr;

    logic [2:0]  lat_cnt;
    logic        cur_write;   // direction of the cycle in flight; survives a flush
    logic        suppress;    // clear seen during DB0/DB1: no rsp, no pop

    logic        push;
    logic        pop;
    logic        last_db1;
    logic        enter_db0;

    assign head      = fifo_mem[rd_ptr];

    // Ready looks only at the registered count, so a full FIFO refuses a push
    // even in the cycle it pops.
    assign req_ready = (count < FULL_COUNT) && !clear;
    assign push      = req_valid && req_ready;
    assign last_db1  = (state == DB1) && (lat_cnt == 3'd1);

    // A flush earlier in this memory cycle already emptied the FIFO, so the
    // completing cycle must not pop whatever was pushed after the flush.
    assign pop       = last_db1 && !suppress && !clear;
    assign enter_db0 = (state == WAIT_BRK) && (state_next == DB0);

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first; a path that left one
        // unassigned would infer a latch.
        state_next    = state;
        brk_req       = 1'b0;
        break_in_prog = 1'b0;
        rsp_valid     = 1'b0;

        unique case (state)
            IDLE: begin
                if (count != 2'd0 && !clear) begin
                    state_next = WAIT_BRK;
                end
            end
            WAIT_BRK: begin
                brk_req = 1'b1;
                // A flush empties the FIFO, so it wins over a grant.
                if (clear) begin
                    state_next = IDLE;
                end else if (brk_grant) begin
                    state_next = DB0;
                end
            end
            DB0: begin
                break_in_prog = 1'b1;
                state_next    = DB1;
            end
            DB1: begin
                break_in_prog = 1'b1;
                if (last_db1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid  = !suppress;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; count and the
        // pointers decide which entries are meaningful.
        if (push) begin
            fifo_mem[wr_ptr] <= '{write: req_write, addr: req_addr, data: req_data};
        end
    end

    // ------------------------------------------------------------------------
    // Memory-side datapath, latency counter, response data
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            rsp_data  <= '0;
            lat_cnt   <= 3'd0;
            cur_write <= 1'b0;
            suppress  <= 1'b0;
        end else begin
            // Strobes are high for exactly the DB0 cycle.
            mem_we <= enter_db0 && head.write;
            mem_re <= enter_db0 && !head.write;

            // Address and data are captured at DB0 entry and held through DB1.
            if (enter_db0) begin
                mem_addr  <= head.addr;
                mem_wdata <= head.data;
                cur_write <= head.write;
            end

            if (state == DB0) begin
                lat_cnt <= LAT_INIT;
            end else if (state == DB1) begin
                lat_cnt <= lat_cnt - 3'd1;
            end

            if (last_db1 && !cur_write) begin
                rsp_data <= mem_rdata;
            end

            if (state == RESP) begin
                suppress <= 1'b0;
            end else if (clear && (state == DB0 || state == DB1)) begin
                suppress <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rk8e_databreak.sv
// -----------------------------------------------------------------------------
// tb_rk8e_databreak
//
// Self-checking bench for rk8e_databreak (MEM_LAT = 2). A small memory model
// answers the DUT's strobes, returning corrupted data until MEM_LAT cycles
// after a read strobe. The reference model is a queue of accepted requests
// plus a reference memory image; each served word is checked against the
// expected break/strobe/response timeline.
// -----------------------------------------------------------------------------
module tb_rk8e_databreak;

    localparam int MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [0:14] req_addr;
    logic [0:11] req_data;
    logic        rsp_valid;
    logic [0:11] rsp_data;
    logic        brk_req;
    logic        brk_grant;
    logic        break_in_prog;
    logic [0:14] mem_addr;
    logic [0:11] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [0:11] mem_rdata;
    logic [1:0]  count;

    always #5 clk = ~clk;

    rk8e_databreak #(.MEM_LAT(MEM_LAT), .DEPTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .brk_req      (brk_req),
        .brk_grant    (brk_grant),
        .break_in_prog(break_in_prog),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata),
        .count        (count)
    );

    typedef struct {
        logic        wr;
        logic [14:0] addr;
        logic [11:0] data;
    } req_t;

    int total = 0;
    int bad   = 0;

    // ---------------- memory environment ----------------
    logic        pre_we = 1'b0;
    logic [14:0] pre_addr = '0;
    logic [11:0] pre_data = '0;
    logic [11:0] env_mem [0:32767];
    logic [14:0] rd_addr_q = '0;
    int          rd_age = 1000;
    int          we_cnt = 0;
    int          re_cnt = 0;

    always @(posedge clk) begin
        if (pre_we) env_mem[pre_addr] <= pre_data;
        else if (mem_we) env_mem[mem_addr] <= mem_wdata;
        if (mem_re) begin
            rd_addr_q <= mem_addr;
            rd_age    <= 0;
        end else if (rd_age < 1000) begin
            rd_age <= rd_age + 1;
        end
        if (mem_we) we_cnt <= we_cnt + 1;
        if (mem_re) re_cnt <= re_cnt + 1;
    end

    // Data is valid MEM_LAT cycles after the strobe; inverted garbage before.
    assign mem_rdata = (rd_age >= MEM_LAT - 1) ? env_mem[rd_addr_q] : ~env_mem[rd_addr_q];

    // ---------------- reference model ----------------
    logic [11:0] ref_mem [0:32767];
    logic [11:0] last_rsp = '0;
    req_t        exp_q [$];
    logic [14:0] pool [0:5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [14:0] a, input logic [11:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_we   = 1'b0;
        ref_mem[a] = d;
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.wr   = 1'($urandom_range(0, 1));
        r.addr = pool[$urandom_range(0, 5)];
        r.data = 12'($urandom);
        return r;
    endfunction

    // Push one request the model expects to be accepted.
    task automatic push(input req_t r);
        req_valid = 1'b1;
        req_write = r.wr;
        req_addr  = r.addr;
        req_data  = r.data;
        tick();
        req_valid = 1'b0;
        exp_q.push_back(r);
        total++;
        if (count !== 2'(exp_q.size())) begin
            bad++;
            $display("FAIL push_count got=%0d want=%0d", count, exp_q.size());
        end
    endtask

    // Serve the head of the model queue: wait for brk_req, grant after gdelay
    // cycles, then check DB0, MEM_LAT DB1 cycles and the RESP cycle.
    task automatic serve_one(input int gdelay);
        req_t        r;
        int          n = 0;
        logic [11:0] exp_d;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL serve_model_empty got=0 want>0");
            return;
        end
        r = exp_q.pop_front();
        while (brk_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (brk_req !== 1'b1) begin
            bad++;
            $display("FAIL brk_req_timeout got=%b want=1", brk_req);
            return;
        end
        repeat (gdelay) tick();
        brk_grant = 1'b1;
        tick();
        brk_grant = 1'b0;
        total++;
        if ({mem_we, mem_re, break_in_prog, brk_req} !== {r.wr, ~r.wr, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL db0_ctrl got=%b want=%b", {mem_we, mem_re, break_in_prog, brk_req},
                     {r.wr, ~r.wr, 1'b1, 1'b0});
        end
        total++;
        if (mem_addr !== r.addr || (r.wr && mem_wdata !== r.data)) begin
            bad++;
            $display("FAIL db0_bus got=%o/%o want=%o/%o", mem_addr, mem_wdata, r.addr, r.data);
        end
        for (int i = 0; i < MEM_LAT; i++) begin
            tick();
            total++;
            if ({mem_we, mem_re, break_in_prog, rsp_valid} !== 4'b0010) begin
                bad++;
                $display("FAIL db1_ctrl cyc=%0d got=%b want=0010", i,
                         {mem_we, mem_re, break_in_prog, rsp_valid});
            end
        end
        tick();
        exp_d = r.wr ? last_rsp : ref_mem[r.addr];
        total++;
        if (rsp_valid !== 1'b1 || break_in_prog !== 1'b0 || rsp_data !== exp_d) begin
            bad++;
            $display("FAIL resp got=v%b bip%b d%o want=v1 bip0 d%o", rsp_valid, break_in_prog,
                     rsp_data, exp_d);
        end
        if (r.wr) ref_mem[r.addr] = r.data;
        else last_rsp = exp_d;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_data = '0; brk_grant = 1'b0;
        tick();
        tick();
        total++;
        if ({brk_req, break_in_prog, mem_we, mem_re, rsp_valid, req_ready} !== 6'b000001 ||
            count !== 2'd0 || rsp_data !== 12'o0 || mem_addr !== 15'o0 || mem_wdata !== 12'o0) begin
            bad++;
            $display("FAIL reset_state got=%b cnt=%0d d=%o a=%o w=%o want=000001 0 0 0 0",
                     {brk_req, break_in_prog, mem_we, mem_re, rsp_valid, req_ready}, count,
                     rsp_data, mem_addr, mem_wdata);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_read();
        req_t r;
        int   we0, re0;
        preload(15'o05432, 12'o1234);
        we0 = we_cnt; re0 = re_cnt;
        r.wr = 1'b0; r.addr = 15'o05432; r.data = 12'o0;
        push(r);
        total++;
        if (brk_req !== 1'b0) begin
            bad++; $display("FAIL read_brk_early got=%b want=0", brk_req);
        end
        tick();
        total++;
        if (brk_req !== 1'b1) begin
            bad++; $display("FAIL read_brk_t1 got=%b want=1", brk_req);
        end
        serve_one(3);
        tick();
        total++;
        if (rsp_valid !== 1'b0 || rsp_data !== 12'o1234) begin
            bad++; $display("FAIL read_after got=v%b d%o want=v0 d1234", rsp_valid, rsp_data);
        end
        total++;
        if (we_cnt - we0 !== 0 || re_cnt - re0 !== 1) begin
            bad++; $display("FAIL read_strobes got=we%0d re%0d want=we0 re1", we_cnt - we0, re_cnt - re0);
        end
    endtask

    task automatic test_write();
        req_t r;
        int   we0, re0;
        we0 = we_cnt; re0 = re_cnt;
        r.wr = 1'b1; r.addr = 15'o17777; r.data = 12'o7070;
        push(r);
        serve_one(0);
        tick();
        total++;
        if (rsp_valid !== 1'b0 || rsp_data !== 12'o1234) begin
            bad++; $display("FAIL write_after got=v%b d%o want=v0 d1234", rsp_valid, rsp_data);
        end
        total++;
        if (we_cnt - we0 !== 1 || re_cnt - re0 !== 0) begin
            bad++; $display("FAIL write_strobes got=we%0d re%0d want=we1 re0", we_cnt - we0, re_cnt - re0);
        end
    endtask

    task automatic test_full_fifo();
        req_t a, b, c;
        a = rand_req(); b = rand_req(); c = rand_req();
        push(a);
        push(b);
        req_valid = 1'b1; req_write = c.wr; req_addr = c.addr; req_data = c.data;
        total++;
        if (req_ready !== 1'b0 || count !== 2'd2) begin
            bad++; $display("FAIL full_refuse got=rdy%b cnt%0d want=rdy0 cnt2", req_ready, count);
        end
        serve_one(1);
        // Pop edge with req_valid high: no push, count 2 -> 1.
        total++;
        if (count !== 2'd1 || req_ready !== 1'b1) begin
            bad++; $display("FAIL full_pop got=cnt%0d rdy%b want=cnt1 rdy1", count, req_ready);
        end
        tick();
        req_valid = 1'b0;
        exp_q.push_back(c);
        total++;
        if (count !== 2'd2 || brk_req !== 1'b0) begin
            bad++; $display("FAIL full_repush got=cnt%0d brk%b want=cnt2 brk0", count, brk_req);
        end
        serve_one(0);
        tick();
        serve_one(2);
        tick();
        total++;
        if (count !== 2'd0) begin
            bad++; $display("FAIL full_drain got=%0d want=0", count);
        end
    endtask

    task automatic test_clear_wait();
        int strobes0;
        push(rand_req());
        push(rand_req());
        tick();
        strobes0 = we_cnt + re_cnt;
        clear = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = pool[0]; req_data = 12'o5555;
        total++;
        if (req_ready !== 1'b0 || brk_req !== 1'b1) begin
            bad++; $display("FAIL clear_w_pre got=rdy%b brk%b want=rdy0 brk1", req_ready, brk_req);
        end
        tick();
        clear = 1'b0;
        req_valid = 1'b0;
        exp_q.delete();
        total++;
        if (brk_req !== 1'b0 || count !== 2'd0) begin
            bad++; $display("FAIL clear_w_post got=brk%b cnt%0d want=brk0 cnt0", brk_req, count);
        end
        brk_grant = 1'b1;
        repeat (3) tick();
        brk_grant = 1'b0;
        total++;
        if (we_cnt + re_cnt !== strobes0 || brk_req !== 1'b0 || break_in_prog !== 1'b0 || count !== 2'd0) begin
            bad++; $display("FAIL clear_w_idle got=str%0d brk%b bip%b cnt%0d want=str%0d 0 0 0",
                            we_cnt + re_cnt, brk_req, break_in_prog, count, strobes0);
        end
    endtask

    task automatic test_clear_db();
        req_t r, nr;
        int   n, we0, seen;
        // clear during DB1 of a write
        r.wr = 1'b1; r.addr = pool[1]; r.data = 12'($urandom);
        push(r);
        void'(exp_q.pop_front());
        we0 = we_cnt;
        n = 0;
        while (brk_req !== 1'b1 && n < 20) begin tick(); n++; end
        brk_grant = 1'b1;
        tick();
        brk_grant = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++;
        if (count !== 2'd0 || break_in_prog !== 1'b1) begin
            bad++; $display("FAIL clear_db1 got=cnt%0d bip%b want=cnt0 bip1", count, break_in_prog);
        end
        seen = 0;
        repeat (6) begin
            tick();
            if (rsp_valid === 1'b1) seen++;
        end
        total++;
        if (seen !== 0 || we_cnt - we0 !== 1 || count !== 2'd0 || break_in_prog !== 1'b0 || brk_req !== 1'b0) begin
            bad++; $display("FAIL clear_db1_end got=rsp%0d we%0d cnt%0d bip%b brk%b want=0 1 0 0 0",
                            seen, we_cnt - we0, count, break_in_prog, brk_req);
        end
        ref_mem[r.addr] = r.data;

        // clear during DB0 of a read, then push during DB1: no rsp, no pop
        r.wr = 1'b0; r.addr = pool[2]; r.data = '0;
        push(r);
        void'(exp_q.pop_front());
        n = 0;
        while (brk_req !== 1'b1 && n < 20) begin tick(); n++; end
        brk_grant = 1'b1;
        tick();
        brk_grant = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        nr.wr = 1'b0; nr.addr = pool[3]; nr.data = '0;
        push(nr);
        tick();
        total++;
        if (rsp_valid !== 1'b0 || count !== 2'd1) begin
            bad++; $display("FAIL clear_db0_resp got=v%b cnt%0d want=v0 cnt1", rsp_valid, count);
        end
        tick();
        serve_one(1);
        tick();
        total++;
        if (count !== 2'd0) begin
            bad++; $display("FAIL clear_db0_drain got=%0d want=0", count);
        end
    endtask

    task automatic test_reset_db0();
        req_t r;
        int   n;
        r.wr = 1'b0; r.addr = pool[4]; r.data = '0;
        push(r);
        exp_q.delete();
        n = 0;
        while (brk_req !== 1'b1 && n < 20) begin tick(); n++; end
        brk_grant = 1'b1;
        tick();
        brk_grant = 1'b0;
        total++;
        if (mem_re !== 1'b1 || break_in_prog !== 1'b1) begin
            bad++; $display("FAIL rst_db0_pre got=re%b bip%b want=re1 bip1", mem_re, break_in_prog);
        end
        reset = 1'b1;
        tick();
        total++;
        if ({brk_req, break_in_prog, mem_we, mem_re, rsp_valid, req_ready} !== 6'b000001 ||
            count !== 2'd0 || rsp_data !== 12'o0 || mem_addr !== 15'o0 || mem_wdata !== 12'o0) begin
            bad++;
            $display("FAIL rst_db0_post got=%b cnt=%0d d=%o a=%o w=%o want=000001 0 0 0 0",
                     {brk_req, break_in_prog, mem_we, mem_re, rsp_valid, req_ready}, count,
                     rsp_data, mem_addr, mem_wdata);
        end
        reset = 1'b0;
        last_rsp = '0;
        tick();
        r.addr = pool[5];
        push(r);
        serve_one(0);
        tick();
    endtask

    task automatic test_random();
        int k;
        for (int it = 0; it < 16; it++) begin
            k = $urandom_range(1, 2);
            for (int j = 0; j < k; j++) push(rand_req());
            for (int j = 0; j < k; j++) begin
                serve_one($urandom_range(0, 3));
                tick();
            end
        end
        total++;
        if (count !== 2'd0 || brk_req !== 1'b0) begin
            bad++; $display("FAIL random_end got=cnt%0d brk%b want=cnt0 brk0", count, brk_req);
        end
    endtask

    initial begin
        test_reset();
        for (int i = 0; i < 6; i++) begin
            pool[i] = 15'($urandom) | 15'o00100;
            preload(pool[i], 12'($urandom));
        end
        test_read();
        test_write();
        test_full_fifo();
        test_clear_wait();
        test_clear_db();
        test_reset_db0();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
